ram_arb_ctrl: RTL and testbench

RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

---
 rtl/ram_arb_if.sv | 35 +++
 rtl/ram_arb_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_arb_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_if.sv
// Two-requester command/response bundle between requesters and the RAM arbiter.
interface ram_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Round-robin two-port arbiter in front of a single RAM, with a full clear
// sequence after reset and on request.
module ram_arb_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  ram_arb_if.slave          bus,
  output logic              init_done,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_END = CNT_ONE << ADDR_W;
  localparam logic            PTR_A   = 1'b0;
  localparam logic            PTR_B   = 1'b1;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic              ptr_reg, ptr_next;

  logic              a_gnt_c, b_gnt_c, accept;
  logic              win_b, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              rd_own0_reg;
  logic              rd_s1_reg, rd_own1_reg;
  logic              a_rvalid_reg, b_rvalid_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; cnt_reg counts clear writes already presented.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        if (cnt_reg == CNT_END) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RUN: begin
        if (clr) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: grants only in RUN and never in a clr cycle.
  always_comb begin
    a_gnt_c   = 1'b0;
    b_gnt_c   = 1'b0;
    init_done = (state_reg == RUN);
    if (state_reg == RUN && !clr) begin
      a_gnt_c = bus.a_req & (~bus.b_req | (ptr_reg == PTR_A));
      b_gnt_c = bus.b_req & (~bus.a_req | (ptr_reg == PTR_B));
    end
  end

  assign accept    = a_gnt_c | b_gnt_c;
  assign win_b     = b_gnt_c;
  assign win_we    = win_b ? bus.b_we    : bus.a_we;
  assign win_addr  = win_b ? bus.b_addr  : bus.a_addr;
  assign win_wdata = win_b ? bus.b_wdata : bus.a_wdata;

  assign ptr_next = a_gnt_c ? PTR_B : (b_gnt_c ? PTR_A : ptr_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= PTR_A;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // RAM command ports: clear writes in INIT, the winning command in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_write_en   <= 1'b0;
      ram_write_addr <= '0;
      ram_write_data <= '0;
      ram_read_en    <= 1'b0;
      ram_read_addr  <= '0;
      rd_own0_reg    <= 1'b0;
    end else begin
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      if (state_reg == INIT) begin
        if (cnt_reg != CNT_END) begin
          ram_write_en   <= 1'b1;
          ram_write_addr <= cnt_reg[ADDR_W-1:0];
          ram_write_data <= '0;
        end
      end else if (accept) begin
        if (win_we) begin
          ram_write_en   <= 1'b1;
          ram_write_addr <= win_addr;
          ram_write_data <= win_wdata;
        end else begin
          ram_read_en    <= 1'b1;
          ram_read_addr  <= win_addr;
          rd_own0_reg    <= win_b;
        end
      end
    end
  end

  // Read return pipeline; keeps running across clr so in-flight reads complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1_reg    <= 1'b0;
      rd_own1_reg  <= 1'b0;
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
    end else begin
      rd_s1_reg    <= ram_read_en;
      rd_own1_reg  <= rd_own0_reg;
      a_rvalid_reg <= rd_s1_reg & ~rd_own1_reg;
      b_rvalid_reg <= rd_s1_reg &  rd_own1_reg;
    end
  end

  assign bus.a_gnt    = a_gnt_c;
  assign bus.b_gnt    = b_gnt_c;
  assign bus.a_rvalid = a_rvalid_reg;
  assign bus.b_rvalid = b_rvalid_reg;
  assign bus.a_rdata  = ram_read_data;
  assign bus.b_rdata  = ram_read_data;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed bench for ram_arb_ctrl with a behavioural two-stage RAM model.
module tb_ram_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       init_done;
  logic       ram_write_en;
  logic [7:0] ram_write_addr;
  logic [3:0] ram_write_data;
  logic       ram_read_en;
  logic [7:0] ram_read_addr;
  logic [3:0] ram_read_data = 4'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic       fill_req;
  logic [3:0] mem [0:255];
  logic       rd_en_q = 1'b0;
  logic [7:0] rd_addr_q = 8'h00;

  ram_arb_if #(.ADDR_W(8), .DATA_W(4)) bus ();

  ram_arb_ctrl #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .bus            (bus),
    .init_done      (init_done),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data)
  );

  always #5 clk = ~clk;

  // RAM: input stage captures the read command, output stage returns data.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'hA;
    end else if (ram_write_en) begin
      mem[ram_write_addr] <= ram_write_data;
    end
    rd_en_q   <= ram_read_en;
    rd_addr_q <= ram_read_addr;
    if (rd_en_q) ram_read_data <= mem[rd_addr_q];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit who, input bit req, input bit we, input logic [7:0] addr,
                       input logic [3:0] data);
    if (who) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
    end
  endtask

  // Presents one command from a single requester; returns one negedge after acceptance.
  task automatic issue(input bit who, input bit we, input logic [7:0] addr, input logic [3:0] data);
    drive(who, 1'b1, we, addr, data);
    #1;
    chk(who ? "gnt_b" : "gnt_a", 32'({bus.a_gnt, bus.b_gnt}), 32'(who ? 2'b01 : 2'b10));
    @(negedge clk);
    drive(who, 1'b0, we, addr, data);
    #1;
    if (we)
      chk("wr_port", 32'({ram_write_en, ram_read_en, ram_write_addr, ram_write_data}),
          32'({2'b10, addr, data}));
    else
      chk("rd_port", 32'({ram_write_en, ram_read_en, ram_read_addr}), 32'({2'b01, addr}));
    $display("cmd req=%s we=%0d addr=%0d data=%0d", who ? "B" : "A", we, addr, data);
  endtask

  task automatic expect_read(input bit who, input logic [3:0] exp);
    logic [3:0] got;
    chk("rv_e1", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(2'b00));
    @(negedge clk); #1;
    chk("rv_e2", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(2'b00));
    @(negedge clk); #1;
    got = who ? bus.b_rdata : bus.a_rdata;
    chk("rv_e3", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(who ? 2'b01 : 2'b10));
    chk("rdata", 32'(got), 32'(exp));
    $display("read req=%s data=%0d expected=%0d", who ? "B" : "A", got, exp);
    @(negedge clk); #1;
    chk("rv_e4", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(2'b00));
  endtask

  // Entered at the negedge where clear address 'first' should be on the write port.
  task automatic run_clear(input int first);
    for (int k = first; k < 256; k++) begin
      #1;
      chk("clear", 32'({ram_write_en, ram_read_en, bus.a_gnt, bus.b_gnt, init_done,
                        bus.a_rvalid, bus.b_rvalid, ram_write_addr, ram_write_data}),
          32'({7'b1000000, 8'(k), 4'h0}));
      clr = (k == 10);
      if (k == 255) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    chk("init_done", 32'({init_done, ram_write_en, bus.a_gnt, bus.b_gnt}), 32'(4'b1000));
    $display("clear sequence from %0d complete, init_done=%0d", first, init_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, bi;
    bit exp_a;
    rst_n = 1'b0;
    clr = 1'b0;
    fill_req = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
    repeat (3) @(negedge clk);
    fill_req = 1'b0;

    // Reset values with both requesters asking.
    drive(1'b0, 1'b1, 1'b0, 8'd1, 4'd0);
    drive(1'b1, 1'b1, 1'b1, 8'd2, 4'd5);
    #1;
    chk("reset", 32'({ram_write_en, ram_read_en, bus.a_gnt, bus.b_gnt, bus.a_rvalid,
                      bus.b_rvalid, init_done, ram_write_addr, ram_read_addr}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_clear(0);

    // A writes 5 <- 9 then reads it back; unwritten 6 reads 0.
    issue(1'b0, 1'b1, 8'd5, 4'd9);
    issue(1'b0, 1'b0, 8'd5, 4'd0);
    expect_read(1'b0, 4'd9);
    issue(1'b0, 1'b0, 8'd6, 4'd0);
    expect_read(1'b0, 4'd0);

    // B writes 7 <- 3, A reads 7 on the very next edge.
    issue(1'b1, 1'b1, 8'd7, 4'd3);
    issue(1'b0, 1'b0, 8'd7, 4'd0);
    expect_read(1'b0, 4'd3);
    issue(1'b1, 1'b0, 8'd7, 4'd0);
    expect_read(1'b1, 4'd3);

    // Both requesters hold req: strict alternation, one write per cycle.
    ai = 0;
    bi = 0;
    drive(1'b0, 1'b1, 1'b1, 8'd20, 4'd1);
    drive(1'b1, 1'b1, 1'b1, 8'd40, 4'd8);
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      chk("rr_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'(exp_a ? 2'b10 : 2'b01));
      @(negedge clk); #1;
      if (exp_a)
        chk("rr_port", 32'({ram_write_en, ram_read_en, ram_write_addr, ram_write_data}),
            32'({2'b10, 8'(20 + ai), 4'(1 + ai)}));
      else
        chk("rr_port", 32'({ram_write_en, ram_read_en, ram_write_addr, ram_write_data}),
            32'({2'b10, 8'(40 + bi), 4'(8 + bi)}));
      $display("rr cycle %0d winner=%s addr=%0d", i, exp_a ? "A" : "B", ram_write_addr);
      if (exp_a) begin
        ai++;
        drive(1'b0, 1'b1, 1'b1, 8'(20 + ai), 4'(1 + ai));
      end else begin
        bi++;
        drive(1'b1, 1'b1, 1'b1, 8'(40 + bi), 4'(8 + bi));
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    issue(1'b0, 1'b0, 8'd22, 4'd0);
    expect_read(1'b0, 4'd3);
    issue(1'b1, 1'b0, 8'd41, 4'd0);
    expect_read(1'b1, 4'd9);

    // Read accepted, then clr: read still returns, clear reruns.
    issue(1'b0, 1'b0, 8'd5, 4'd0);
    clr = 1'b1;
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    #1;
    chk("clr_gnt", 32'({bus.a_gnt, bus.b_gnt, init_done}), 32'(3'b001));
    @(negedge clk);
    clr = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    #1;
    chk("clr_edge", 32'({init_done, ram_write_en, ram_read_en, bus.a_rvalid}), 32'(0));
    @(negedge clk); #1;
    chk("clr_rvalid", 32'({bus.a_rvalid, bus.b_rvalid, bus.a_rdata}), 32'({2'b10, 4'd9}));
    chk("clr_first", 32'({ram_write_en, ram_write_addr}), 32'({1'b1, 8'd0}));
    $display("clr: in-flight read data=%0d, clear restarted", bus.a_rdata);
    @(negedge clk);
    run_clear(1);
    issue(1'b0, 1'b0, 8'd5, 4'd0);
    expect_read(1'b0, 4'd0);

    // Reset during an in-flight read: no rvalid afterwards.
    issue(1'b0, 1'b0, 8'd5, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_rd", 32'({ram_read_en, ram_write_en, bus.a_rvalid, init_done}), 32'(0));
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_rv", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_clear(0);

    // Reset at clear address 100, then the clear restarts from 0.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    repeat (100) @(negedge clk);
    #1;
    chk("pre_rst", 32'({ram_write_en, ram_write_addr}), 32'({1'b1, 8'd100}));
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({ram_write_en, ram_read_en, bus.a_gnt, bus.b_gnt, init_done,
                        bus.a_rvalid, bus.b_rvalid, ram_write_addr}), 32'(0));
    $display("reset at clear address 100: write_en=%0d", ram_write_en);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_clear(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
